// File: rtl/arbitro_matriz_pkg.sv
// pacote_jogo: cell codes, controller state encoding, winner codes and default grid size
package pacote_jogo;
    typedef logic [1:0] celula_t;
    localparam celula_t LIVRE    = 2'd0;
    localparam celula_t TRACO_J1 = 2'd1;
    localparam celula_t PAREDE   = 2'd2;
    localparam celula_t TRACO_J2 = 2'd3;
    localparam logic [2:0] LIMPA  = 3'd0;
    localparam logic [2:0] ESPERA = 3'd1;
    localparam logic [2:0] ESC_J1 = 3'd2;
    localparam logic [2:0] ESC_J2 = 3'd3;
    localparam logic [2:0] LE_J1  = 3'd4;
    localparam logic [2:0] LE_J2  = 3'd5;
    localparam logic [2:0] DECIDE = 3'd6;
    localparam logic [2:0] FIM    = 3'd7;
    localparam logic [1:0] SEM_VENCEDOR = 2'd0;
    localparam logic [1:0] VENCE_J1     = 2'd1;
    localparam logic [1:0] VENCE_J2     = 2'd2;
    localparam logic [1:0] EMPATE       = 2'd3;
    localparam int COLUNAS_PADRAO = 80;
    localparam int LINHAS_PADRAO  = 60;
endpackage

// File: rtl/arbitro_matriz_if.sv
// arbitro_matriz_if: player coordinates, game status and display read port of the grid arbiter
interface arbitro_matriz_if;
    import pacote_jogo::*;
    logic       reiniciar;
    logic [6:0] atual_x_j1, futura_x_j1, atual_x_j2, futura_x_j2;
    logic [5:0] atual_y_j1, futura_y_j1, atual_y_j2, futura_y_j2;
    logic       passo, limpando, fim_de_jogo;
    logic [1:0] vencedor;
    logic [6:0] disp_x;
    logic [5:0] disp_y;
    celula_t    disp_celula;
    modport master (
        output reiniciar, atual_x_j1, atual_y_j1, futura_x_j1, futura_y_j1,
               atual_x_j2, atual_y_j2, futura_x_j2, futura_y_j2, disp_x, disp_y,
        input  passo, limpando, fim_de_jogo, vencedor, disp_celula
    );
    modport slave (
        input  reiniciar, atual_x_j1, atual_y_j1, futura_x_j1, futura_y_j1,
               atual_x_j2, atual_y_j2, futura_x_j2, futura_y_j2, disp_x, disp_y,
        output passo, limpando, fim_de_jogo, vencedor, disp_celula
    );
endinterface

// File: rtl/arbitro_matriz_memoria.sv
// memoria_matriz: true dual-port grid RAM; port A display read, port B controller read/write
module memoria_matriz
    import pacote_jogo::*;
#(
    parameter int PROF = COLUNAS_PADRAO * LINHAS_PADRAO,
    parameter int AW   = $clog2(PROF)
)(
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          en_a,
    input  logic [AW-1:0] end_a,
    output celula_t       q_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic [AW-1:0] end_b,
    input  celula_t       d_b,
    output celula_t       q_b
);
    celula_t mem [PROF];

    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) q_a <= LIVRE;
        else if (en_a) q_a <= mem[end_a];

    // non-blocking read alongside the write gives old data on a same-address collision
    always_ff @(posedge CLOCK_50)
        if (en_b) begin
            if (we_b) mem[end_b] <= d_b;
            q_b <= mem[end_b];
        end
endmodule

// File: rtl/arbitro_matriz.sv
// arbitro_matriz: owns the shared game grid, sweeps it clear, runs each tick's trail writes and collision reads
module arbitro_matriz
    import pacote_jogo::*;
#(
    parameter int COLUNAS     = COLUNAS_PADRAO,
    parameter int LINHAS      = LINHAS_PADRAO,
    parameter int BORDA       = 2,
    parameter int TICK_CICLOS = 3000000
)(
    input logic             CLOCK_50,
    input logic             reset,
    arbitro_matriz_if.slave bus
);
    localparam int AW = $clog2(COLUNAS * LINHAS);
    localparam logic [6:0]  ULT_COL  = 7'(COLUNAS - 1);
    localparam logic [5:0]  ULT_LIN  = 6'(LINHAS - 1);
    localparam logic [21:0] ULT_TICK = 22'(TICK_CICLOS - 1);

    logic [2:0]    estado;
    logic [6:0]    coluna, ax1, fx1, ax2, fx2;
    logic [5:0]    linha, ay1, fy1, ay2, fy2;
    logic [21:0]   cnt;
    celula_t       c1, q_b, d_b;
    logic [AW-1:0] end_b;
    logic          en_b, we_b, parede, fora_f1, fora_f2, dentro_a1, dentro_a2, frente, col1, col2;

    function automatic logic [AW-1:0] ender(input logic [6:0] x, input logic [5:0] y);
        return AW'(y) * AW'(COLUNAS) + AW'(x);
    endfunction

    always_comb begin
        parede    = linha < 6'(BORDA) || linha >= 6'(LINHAS - BORDA) ||
                    coluna < 7'(BORDA) || coluna >= 7'(COLUNAS - BORDA);
        fora_f1   = fx1 >= 7'(COLUNAS) || fy1 >= 6'(LINHAS);
        fora_f2   = fx2 >= 7'(COLUNAS) || fy2 >= 6'(LINHAS);
        dentro_a1 = ax1 < 7'(COLUNAS) && ay1 < 6'(LINHAS);
        dentro_a2 = ax2 < 7'(COLUNAS) && ay2 < 6'(LINHAS);
        frente    = fx1 == fx2 && fy1 == fy2;
        col1      = fora_f1 || c1 != LIVRE || frente;
        col2      = fora_f2 || q_b != LIVRE || frente;
        end_b     = estado == LIMPA  ? ender(coluna, linha) :
                    estado == ESC_J1 ? ender(ax1, ay1) :
                    estado == ESC_J2 ? ender(ax2, ay2) :
                    estado == LE_J1  ? ender(fx1, fy1) : ender(fx2, fy2);
        // a restart request suppresses every access so an aborted round leaves no trail
        we_b      = !bus.reiniciar && (estado == LIMPA || (estado == ESC_J1 && dentro_a1) ||
                    (estado == ESC_J2 && dentro_a2));
        en_b      = we_b || (!bus.reiniciar && ((estado == LE_J1 && !fora_f1) ||
                    (estado == LE_J2 && !fora_f2)));
        d_b       = estado == LIMPA ? (parede ? PAREDE : LIVRE) :
                    estado == ESC_J1 ? TRACO_J1 : TRACO_J2;
    end

    always_ff @(posedge CLOCK_50 or negedge reset)
        if (!reset) begin
            estado          <= LIMPA;
            linha           <= '0;
            coluna          <= '0;
            cnt             <= '0;
            bus.passo       <= 1'b0;
            bus.limpando    <= 1'b1;
            bus.fim_de_jogo <= 1'b0;
            bus.vencedor    <= SEM_VENCEDOR;
        end else if (bus.reiniciar) begin
            estado          <= LIMPA;
            linha           <= '0;
            coluna          <= '0;
            bus.passo       <= 1'b0;
            bus.limpando    <= 1'b1;
            bus.fim_de_jogo <= 1'b0;
            bus.vencedor    <= SEM_VENCEDOR;
        end else begin
            bus.passo <= 1'b0;
            case (estado)
                LIMPA: begin
                    coluna <= coluna == ULT_COL ? '0 : coluna + 7'd1;
                    if (coluna == ULT_COL) linha <= linha == ULT_LIN ? '0 : linha + 6'd1;
                    if (coluna == ULT_COL && linha == ULT_LIN) begin
                        estado       <= ESPERA;
                        bus.limpando <= 1'b0;
                        cnt          <= '0;
                    end
                end
                ESPERA: begin
                    cnt <= cnt == ULT_TICK ? '0 : cnt + 22'd1;
                    if (cnt == ULT_TICK) estado <= ESC_J1;
                end
                DECIDE: begin
                    estado          <= col1 || col2 ? FIM : ESPERA;
                    bus.passo       <= !(col1 || col2);
                    bus.fim_de_jogo <= col1 || col2;
                    bus.vencedor    <= col1 && col2 ? EMPATE : col1 ? VENCE_J2 :
                                       col2 ? VENCE_J1 : SEM_VENCEDOR;
                end
                FIM: estado <= FIM;
                // ESC_J1 through LE_J2 are consecutive codes, one cycle each
                default: estado <= estado + 3'd1;
            endcase
        end

    always_ff @(posedge CLOCK_50) begin
        if (estado == ESPERA && cnt == ULT_TICK) begin
            ax1 <= bus.atual_x_j1;
            ay1 <= bus.atual_y_j1;
            fx1 <= bus.futura_x_j1;
            fy1 <= bus.futura_y_j1;
            ax2 <= bus.atual_x_j2;
            ay2 <= bus.atual_y_j2;
            fx2 <= bus.futura_x_j2;
            fy2 <= bus.futura_y_j2;
        end
        if (estado == LE_J2) c1 <= q_b;
    end

    memoria_matriz #(.PROF(COLUNAS * LINHAS), .AW(AW)) u_mem (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en_a     (bus.disp_x < 7'(COLUNAS) && bus.disp_y < 6'(LINHAS)),
        .end_a    (ender(bus.disp_x, bus.disp_y)),
        .q_a      (bus.disp_celula),
        .en_b     (en_b),
        .we_b     (we_b),
        .end_b    (end_b),
        .d_b      (d_b),
        .q_b      (q_b)
    );
endmodule
